mb_rx_flit_deser: RTL and testbench
===================================

// Module: mb_rx_flit_deser
// PURPOSE
//  Parametrised mainband receive deserialiser. Samples NUM_LANES data lanes plus valid once per clk (1 UI/clk,
//  lanes already retimed into clk). Checks 8-UI valid framing and assembles bursts into FLIT_BYTES flits.
//  Buffers flits in a FIFO and delivers them with valid/ready backpressure. Sits between MB pads and the RX adapter.
// PARAMETERS
//  NUM_LANES    16  data lanes; power of 2, 8..64, must divide FLIT_BYTES
//  FLIT_BYTES   64  bytes per flit
//  FIFO_DEPTH    4  flit entries; power of 2, >=2
// PORTS
//  clk            in   1                 sampling/system clock
//  reset_n        in   1                 async active-low reset
//  valid_iPin     in   1                 lane valid/framing pin
//  dataPins_i     in   NUM_LANES         data lanes, 1 bit per UI
//  flit_valid_o   out  1                 FIFO head holds a flit
//  flit_ready_i   in   1                 consumer accepts head flit
//  flit_data_o    out  FLIT_BYTES*8      head flit; byte n = [8n+7:8n]
//  frame_err_o    out  1                 1-cycle pulse on framing violation
//  overflow_o     out  1                 sticky: flit dropped, FIFO full
//  clr_sticky_i   in   1                 clears overflow_o
//  fill_level_o   out  $clog2(FIFO_DEPTH)+1  flits in FIFO
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE, ui/frag counters 0, FIFO empty. All outputs 0: flit_valid_o, flit_data_o,
//   frame_err_o, overflow_o, fill_level_o.
//  Burst = 8 consecutive UI: valid_iPin 1 on UI0..3, 0 on UI4..7. Byte mapping: UI u of lane b in fragment f
//   -> bit u of byte f*NUM_LANES+b. FRAGS = FLIT_BYTES/NUM_LANES bursts per flit (default 4).
//  FSM (ucie_mb_pkg::rx_state_e):
//   IDLE: valid=1 -> HI, store UI0 (ui=1); valid=0 -> stay; lanes ignored.
//   HI (ui 1..3): valid must be 1, store UI, ui++; at ui=3 -> LO. valid=0 -> ERR action.
//   LO (ui 4..7): valid must be 0, store UI; ui=7 ends fragment. valid=1 at ui 4..7 -> ERR action.
//   End of fragment: frag++ (wraps at FRAGS). Next cycle valid=1 -> HI UI0 (back-to-back bursts, no gap);
//    valid=0 -> IDLE. Gaps of any length between bursts are legal; partial flit retained.
//  ERR action (same edge): frame_err_o=1 next cycle, partial flit discarded (frag=0, ui=0), state IDLE.
//   Violating UI is not used to start a new burst.
//  Flit complete on edge sampling UI7 of fragment FRAGS-1: push into FIFO that edge.
//   flit_valid_o rises on the next clk (latency 1 clk from last UI) if FIFO was empty.
//  Output: show-ahead FIFO. flit_data_o = head entry while flit_valid_o=1; pop on flit_valid_o&&flit_ready_i.
//   flit_data_o is don't-care when flit_valid_o=0. Must not change while valid&&!ready.
//  Full: push accepted if fill<FIFO_DEPTH, or fill==FIFO_DEPTH with a pop the same cycle.
//   Otherwise flit dropped, overflow_o set (sticky), FIFO contents untouched.
//  Simultaneous push+pop: fill unchanged. Pointers wrap modulo FIFO_DEPTH; fill uses extra bit.
//  clr_sticky_i: clears overflow_o next cycle; a drop on the same cycle wins (overflow_o stays 1).
//  Reset mid-burst or mid-drain: all state discarded; next burst after release starts at frag 0.
// STRUCTURE
//  ucie_mb_pkg: UI_PER_BURST=8, VALID_HI_UI=4, rx_state_e {IDLE,HI,LO}, flit-byte typedef.
//  Sub-module mb_rx_flit_fifo (WIDTH, DEPTH; push/pop/full/empty/fill; show-ahead).
//  Top: FSM, ui counter [2:0], frag counter $clog2(FRAGS) bits, FLIT_BYTES*8 assembly register.
// TESTING
//  1 Default params, 4 back-to-back bursts, lane b UI u = byte (16f+b) value 8'hA5^(16f+b)
//    -> flit_valid_o 1 clk after last UI, flit_data_o byte n = 8'hA5^n, fill 1.
//  2 valid drops at UI2 of frag 1 -> frame_err_o pulse 1 clk; next 4 clean bursts give one clean flit only.
//  3 ready=0, push 5 flits (DEPTH 4) -> fill 4, overflow_o=1, head = flit 0. Pop 4 -> flits 0..3 in order.
//  4 Full FIFO, flit completes on same cycle as pop -> no drop, overflow_o stays 0, fill stays 4.
//  5 Idle gaps of 0, 1, 37 clk between bursts -> identical flit data; reset_n low at frag 2 -> outputs 0, next flit clean.
//  6 NUM_LANES=32, FLIT_BYTES=64: 2 bursts per flit -> correct byte map; DEPTH 8 wraps pointers twice in order.

Source files
------------

// File: rtl/ucie_mb_pkg.sv
// ----------------------------------------------------------------------------
// ucie_mb_pkg
// Shared definitions for the mainband receive path.
//   UI_PER_BURST : unit intervals in one framed burst
//   VALID_HI_UI  : leading UIs of a burst during which the valid pin is high
//   rx_state_e   : receive framing FSM states
//   flit_byte_t  : one byte of an assembled flit
// ----------------------------------------------------------------------------
package ucie_mb_pkg;

   localparam int UI_PER_BURST = 8;
   localparam int VALID_HI_UI  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2
   } rx_state_e;

   typedef logic [7:0] flit_byte_t;

endpackage

// File: rtl/mb_rx_flit_fifo.sv
// ----------------------------------------------------------------------------
// mb_rx_flit_fifo
// Show-ahead flit FIFO. The head entry is visible on pop_data_o whenever the
// FIFO is not empty and is zero otherwise.
// The caller qualifies push_i/pop_i: push_i only when there is room (or a pop
// happens in the same cycle), pop_i only when not empty.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push_i          write push_data_i into the tail
//   push_data_i     flit to store
//   pop_i           retire the head entry
//   pop_data_o      head entry (show-ahead)
//   full_o/empty_o  occupancy flags
//   fill_o          number of stored entries
// ----------------------------------------------------------------------------
module mb_rx_flit_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   fill_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      fill_q, fill_d;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
         2'b10:   fill_d = fill_q + (AW+1)'(1);
         2'b01:   fill_d = fill_q - (AW+1)'(1);
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   // Storage needs no reset: the output is gated by empty_o.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign empty_o    = (fill_q == '0);
   assign full_o     = (fill_q == (AW+1)'(DEPTH));
   assign fill_o     = fill_q;
   assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mb_rx_flit_deser.sv
// ----------------------------------------------------------------------------
// mb_rx_flit_deser
// Mainband receive deserialiser. Samples NUM_LANES lanes plus the valid pin
// once per clk, checks the 4-high/4-low valid framing of each 8-UI burst and
// assembles FLIT_BYTES/NUM_LANES bursts into one flit, which is queued in a
// show-ahead FIFO and handed out with valid/ready.
// Handshake: a flit transfers on every clk edge where flit_valid_o and
// flit_ready_i are both 1; flit_data_o holds steady while valid && !ready.
// Ports:
//   clk, reset_n    clock, async active-low reset
//   valid_iPin      framing pin
//   dataPins_i      data lanes, one bit per UI
//   flit_valid_o    FIFO head holds a flit
//   flit_ready_i    consumer accepts the head flit
//   flit_data_o     head flit, byte n at [8n+7:8n]
//   frame_err_o     one-cycle pulse on a framing violation
//   overflow_o      sticky: a completed flit was dropped because FIFO was full
//   clr_sticky_i    clears overflow_o
//   fill_level_o    number of flits in the FIFO
// ----------------------------------------------------------------------------
module mb_rx_flit_deser
   import ucie_mb_pkg::*;
#(
   parameter int NUM_LANES  = 16,
   parameter int FLIT_BYTES = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            valid_iPin,
   input  logic [NUM_LANES-1:0]            dataPins_i,
   output logic                            flit_valid_o,
   input  logic                            flit_ready_i,
   output logic [FLIT_BYTES*8-1:0]         flit_data_o,
   output logic                            frame_err_o,
   output logic                            overflow_o,
   input  logic                            clr_sticky_i,
   output logic [$clog2(FIFO_DEPTH):0]     fill_level_o
);

   localparam int FRAGS  = FLIT_BYTES / NUM_LANES;
   localparam int FRAG_W = (FRAGS > 1) ? $clog2(FRAGS) : 1;
   localparam int FLIT_W = FLIT_BYTES * 8;
   localparam logic [FRAG_W-1:0] LAST_FRAG = FRAG_W'(FRAGS - 1);
   localparam logic [2:0]        LAST_HI   = 3'(VALID_HI_UI - 1);
   localparam logic [2:0]        LAST_UI   = 3'(UI_PER_BURST - 1);

   rx_state_e          state_q, state_d;
   logic [2:0]         ui_q, ui_d;
   logic [FRAG_W-1:0]  frag_q, frag_d;
   logic [FLIT_W-1:0]  asm_q, asm_d;
   logic               frame_err_q, frame_err_d;
   logic               overflow_q, overflow_d;

   logic               store;
   logic               err;
   logic               flit_done;
   logic               fifo_full, fifo_empty;
   logic               pop_ok, push_ok, drop;

   // Framing FSM and lane-bit capture.
   always_comb begin
      state_d     = state_q;
      ui_d        = ui_q;
      frag_d      = frag_q;
      asm_d       = asm_q;
      frame_err_d = 1'b0;
      store       = 1'b0;
      err         = 1'b0;
      flit_done   = 1'b0;

      case (state_q)
         IDLE: begin
            // ui_q is always 0 here, so this captures UI0.
            if (valid_iPin) begin
               store   = 1'b1;
               ui_d    = 3'd1;
               state_d = HI;
            end
         end
         HI: begin
            if (valid_iPin) begin
               store = 1'b1;
               ui_d  = ui_q + 3'd1;
               if (ui_q == LAST_HI) state_d = LO;
            end else begin
               err = 1'b1;
            end
         end
         LO: begin
            if (!valid_iPin) begin
               store = 1'b1;
               if (ui_q == LAST_UI) begin
                  // IDLE samples the next cycle, so a back-to-back burst
                  // is picked up there without a gap.
                  ui_d    = 3'd0;
                  state_d = IDLE;
                  if (frag_q == LAST_FRAG) begin
                     frag_d    = '0;
                     flit_done = 1'b1;
                  end else begin
                     frag_d = frag_q + FRAG_W'(1);
                  end
               end else begin
                  ui_d = ui_q + 3'd1;
               end
            end else begin
               err = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (store) begin
         for (int b = 0; b < NUM_LANES; b++) begin
            asm_d[(int'(frag_q) * NUM_LANES + b) * 8 + int'(ui_q)] = dataPins_i[b];
         end
      end

      // Violation: throw away the partial flit; the offending UI is not
      // treated as the start of a new burst.
      if (err) begin
         frame_err_d = 1'b1;
         ui_d        = 3'd0;
         frag_d      = '0;
         state_d     = IDLE;
      end
   end

   // A full FIFO still accepts a flit when the head leaves the same cycle.
   assign pop_ok  = flit_ready_i && !fifo_empty;
   assign push_ok = flit_done && (!fifo_full || pop_ok);
   assign drop    = flit_done && !push_ok;

   // A drop in the same cycle as a clear keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (clr_sticky_i) overflow_d = 1'b0;
      if (drop)         overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ui_q        <= 3'd0;
         frag_q      <= '0;
         asm_q       <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ui_q        <= ui_d;
         frag_q      <= frag_d;
         asm_q       <= asm_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   // asm_d carries the final UI, so the complete flit is pushed this edge.
   mb_rx_flit_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (reset_n),
      .push_i      (push_ok),
      .push_data_i (asm_d),
      .pop_i       (pop_ok),
      .pop_data_o  (flit_data_o),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .fill_o      (fill_level_o)
   );

   assign flit_valid_o = !fifo_empty;
   assign frame_err_o  = frame_err_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_mb_rx_flit_deser.sv
// ----------------------------------------------------------------------------
// tb_mb_rx_flit_deser
// Directed bench for mb_rx_flit_deser: a default instance (16 lanes, depth 4)
// and a wide instance (32 lanes, depth 8). Expected flits are queued when
// stimulus is issued and compared by per-instance monitors on each transfer.
// ----------------------------------------------------------------------------
module tb_mb_rx_flit_deser;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;

   // default instance
   logic         v0, rdy0, clr0, fv0, fe0, ov0;
   logic [15:0]  d0;
   logic [511:0] fd0;
   logic [2:0]   fill0;

   // wide instance
   logic         v1, rdy1, clr1, fv1, fe1, ov1;
   logic [31:0]  d1;
   logic [511:0] fd1;
   logic [3:0]   fill1;

   mb_rx_flit_deser #(.NUM_LANES(16), .FLIT_BYTES(64), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .reset_n(reset_n), .valid_iPin(v0), .dataPins_i(d0),
      .flit_valid_o(fv0), .flit_ready_i(rdy0), .flit_data_o(fd0),
      .frame_err_o(fe0), .overflow_o(ov0), .clr_sticky_i(clr0),
      .fill_level_o(fill0)
   );

   mb_rx_flit_deser #(.NUM_LANES(32), .FLIT_BYTES(64), .FIFO_DEPTH(8)) dut1 (
      .clk(clk), .reset_n(reset_n), .valid_iPin(v1), .dataPins_i(d1),
      .flit_valid_o(fv1), .flit_ready_i(rdy1), .flit_data_o(fd1),
      .frame_err_o(fe1), .overflow_o(ov1), .clr_sticky_i(clr1),
      .fill_level_o(fill1)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [511:0] exp_q0[$];
   logic [511:0] exp_q1[$];
   bit lat_probe = 1'b0;

   // Flit k: byte n = 8'hA5 ^ n ^ (k*8'h11); k=0 gives the plain A5^n pattern.
   function automatic logic [511:0] pat(input int k);
      logic [511:0] r;
      for (int n = 0; n < 64; n++) r[n*8 +: 8] = 8'hA5 ^ 8'(n) ^ 8'(k * 17);
      return r;
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && fv0 && rdy0) begin
         if (exp_q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL flit0_unexpected: got %0h expected none", fd0);
         end else begin
            check("flit0", fd0, exp_q0.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && fv1 && rdy1) begin
         if (exp_q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL flit1_unexpected: got %0h expected none", fd1);
         end else begin
            check("flit1", fd1, exp_q1.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_burst(input int inst, input logic [511:0] fl, input int f, input bit pop_last);
      for (int u = 0; u < 8; u++) begin
         if (inst == 0) begin
            v0 = (u < 4);
            for (int b = 0; b < 16; b++) d0[b] = fl[(f*16 + b)*8 + u];
            if (pop_last && u == 7) rdy0 = 1'b1;
            if (lat_probe && u == 7) check("lat_not_early", 512'(fv0), 512'(0));
         end else begin
            v1 = (u < 4);
            for (int b = 0; b < 32; b++) d1[b] = fl[(f*32 + b)*8 + u];
         end
         tick();
         if (pop_last && u == 7) rdy0 = 1'b0;
      end
      if (inst == 0) v0 = 1'b0; else v1 = 1'b0;
   endtask

   task automatic send_flit(input int inst, input logic [511:0] fl, input int gap, input bit pop_last);
      int frags;
      frags = (inst == 0) ? 4 : 2;
      for (int f = 0; f < frags; f++) begin
         if (f > 0) repeat (gap) tick();
         send_burst(inst, fl, f, pop_last && (f == frags - 1));
      end
   endtask

   task automatic wait_drain(input int inst);
      int n;
      n = 0;
      while (((inst == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL drain%0d_timeout: got %0d pending expected 0", inst,
                  (inst == 0) ? exp_q0.size() : exp_q1.size());
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0;
      v0 = 0; d0 = '0; rdy0 = 0; clr0 = 0;
      v1 = 0; d1 = '0; rdy1 = 0; clr1 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 512'(fv0), 512'(0));
      check("rst_data", fd0, 512'(0));
      check("rst_err", 512'(fe0), 512'(0));
      check("rst_ovf", 512'(ov0), 512'(0));
      check("rst_fill", 512'(fill0), 512'(0));
      check("rst_fill1", 512'(fill1), 512'(0));
      reset_n = 1'b1;
      tick();

      // 1: one clean flit, valid exactly one clk after the last UI
      rdy0 = 1'b1;
      exp_q0.push_back(pat(0));
      lat_probe = 1'b1;
      send_flit(0, pat(0), 0, 0);
      lat_probe = 1'b0;
      check("t1_valid", 512'(fv0), 512'(1));
      check("t1_fill", 512'(fill0), 512'(1));
      wait_drain(0);

      // 2: valid drops at UI2 of frag 1
      send_burst(0, pat(1), 0, 0);
      v0 = 1'b1; d0 = 16'h1234; tick();
      tick();
      v0 = 1'b0; tick();
      check("t2_err_pulse", 512'(fe0), 512'(1));
      tick();
      check("t2_err_clear", 512'(fe0), 512'(0));
      exp_q0.push_back(pat(2));
      send_flit(0, pat(2), 0, 0);
      wait_drain(0);
      repeat (3) tick();

      // 3: overflow with consumer stalled
      rdy0 = 1'b0;
      for (int k = 3; k <= 7; k++) begin
         if (k < 7) exp_q0.push_back(pat(k));
         send_flit(0, pat(k), 0, 0);
      end
      tick();
      check("t3_fill", 512'(fill0), 512'(4));
      check("t3_ovf", 512'(ov0), 512'(1));
      check("t3_head", fd0, pat(3));
      rdy0 = 1'b1;
      wait_drain(0);
      tick();
      check("t3_empty", 512'(fill0), 512'(0));
      check("t3_ovf_sticky", 512'(ov0), 512'(1));
      clr0 = 1'b1; tick(); clr0 = 1'b0;
      check("t3_ovf_clr", 512'(ov0), 512'(0));

      // 4: full FIFO, flit completes on a pop cycle
      rdy0 = 1'b0;
      for (int k = 8; k <= 11; k++) begin
         exp_q0.push_back(pat(k));
         send_flit(0, pat(k), 0, 0);
      end
      check("t4_full", 512'(fill0), 512'(4));
      exp_q0.push_back(pat(12));
      send_flit(0, pat(12), 0, 1);
      check("t4_fill", 512'(fill0), 512'(4));
      check("t4_no_ovf", 512'(ov0), 512'(0));
      rdy0 = 1'b1;
      wait_drain(0);

      // 5: inter-burst gaps, then reset mid-drain and mid-flit
      exp_q0.push_back(pat(0)); send_flit(0, pat(0), 0, 0);
      exp_q0.push_back(pat(0)); send_flit(0, pat(0), 1, 0);
      exp_q0.push_back(pat(0)); send_flit(0, pat(0), 37, 0);
      wait_drain(0);
      rdy0 = 1'b0;
      send_flit(0, pat(13), 0, 0);
      send_burst(0, pat(14), 0, 0);
      send_burst(0, pat(14), 1, 0);
      reset_n = 1'b0;
      #2;
      check("t5_rst_valid", 512'(fv0), 512'(0));
      check("t5_rst_data", fd0, 512'(0));
      check("t5_rst_fill", 512'(fill0), 512'(0));
      tick(); tick();
      reset_n = 1'b1;
      tick();
      rdy0 = 1'b1;
      exp_q0.push_back(pat(15));
      send_flit(0, pat(15), 0, 0);
      wait_drain(0);

      // 6: 32 lanes, two bursts per flit, depth 8 wrapped twice
      rdy1 = 1'b0;
      for (int k = 20; k < 28; k++) begin
         exp_q1.push_back(pat(k));
         send_flit(1, pat(k), 0, 0);
      end
      check("t6_fill", 512'(fill1), 512'(8));
      check("t6_head", fd1, pat(20));
      rdy1 = 1'b1;
      wait_drain(1);
      for (int k = 28; k < 38; k++) begin
         exp_q1.push_back(pat(k));
         send_flit(1, pat(k), (k % 3), 0);
      end
      wait_drain(1);
      tick();
      check("t6_empty", 512'(fill1), 512'(0));
      check("t6_no_ovf", 512'(ov1), 512'(0));

      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
